// File: rtl/mem_cfg_pkg.sv
// Shared memory-access types: access width encoding, arbiter port ids and
// the byte count of each width.
package mem_cfg_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } mem_width_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_e;

  // Reserved width encodings report zero bytes so callers can flag them.
  function automatic logic [2:0] width_nbytes(mem_width_t width);
    case (width)
      MEM_BYTE:     return 3'd1;
      MEM_HALFWORD: return 3'd2;
      MEM_WORD:     return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/interleaved_memory.sv
// Byte-addressable memory built from four interleaved byte banks, so any
// byte address can start an access. Reads are registered (1-cycle latency).
module interleaved_memory
  import mem_cfg_pkg::*;
#(
  parameter int MEMORY_DEPTH_BYTES = 1024,
  localparam int AddrWidth = $clog2(MEMORY_DEPTH_BYTES)
) (
  input  logic                 clk_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  mem_width_t           width_i,
  input  logic                 sign_extend_i,
  input  logic [31:0]          data_i,
  input  logic                 we_i,
  output logic [31:0]          data_o
);

  localparam int Rows = MEMORY_DEPTH_BYTES / 4;

  logic [7:0]           bank_q [4][Rows];
  logic [AddrWidth-1:0] byteAddr [4];
  logic [7:0]           rdBytes [4];
  logic [31:0]          rdFmt;
  logic [31:0]          rdata_q;

  // Byte i of the access lives in bank (addr+i)[1:0], row (addr+i)>>2.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byteAddr[i] = addr_i + AddrWidth'(i);
      rdBytes[i]  = bank_q[byteAddr[i][1:0]][byteAddr[i][AddrWidth-1:2]];
    end
  end

  always_comb begin
    rdFmt = '0;
    case (width_i)
      MEM_BYTE:     rdFmt = {{24{sign_extend_i & rdBytes[0][7]}}, rdBytes[0]};
      MEM_HALFWORD: rdFmt = {{16{sign_extend_i & rdBytes[1][7]}}, rdBytes[1], rdBytes[0]};
      default:      rdFmt = {rdBytes[3], rdBytes[2], rdBytes[1], rdBytes[0]};
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && (3'(i) < width_nbytes(width_i))) begin
        bank_q[byteAddr[i][1:0]][byteAddr[i][AddrWidth-1:2]] <= data_i[8*i +: 8];
      end
    end
    rdata_q <= rdFmt;
  end

  assign data_o = rdata_q;

endmodule

// File: rtl/hippo_mem_arbiter.sv
// Round-robin arbiter giving two requesters one access per cycle to a shared
// memory, with range checking and 1-cycle response routing back to each port.
module hippo_mem_arbiter
  import mem_cfg_pkg::*;
#(
  parameter int MEMORY_DEPTH_BYTES = 1024,
  localparam int AddrWidth = $clog2(MEMORY_DEPTH_BYTES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_req_i,
  input  logic                 a_we_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  mem_width_t           a_width_i,
  input  logic                 a_sign_extend_i,
  input  logic [31:0]          a_data_i,
  output logic                 a_gnt_o,
  output logic                 a_rvalid_o,
  output logic                 a_err_o,
  output logic [31:0]          a_rdata_o,
  input  logic                 b_req_i,
  input  logic                 b_we_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  mem_width_t           b_width_i,
  input  logic                 b_sign_extend_i,
  input  logic [31:0]          b_data_i,
  output logic                 b_gnt_o,
  output logic                 b_rvalid_o,
  output logic                 b_err_o,
  output logic [31:0]          b_rdata_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output mem_width_t           mem_width_o,
  output logic                 mem_sign_extend_o,
  output logic [31:0]          mem_data_o,
  output logic                 mem_we_o,
  input  logic [31:0]          mem_data_i
);

  localparam int unsigned LastAddrInt = MEMORY_DEPTH_BYTES - 1;
  localparam logic [AddrWidth:0] LastAddr = LastAddrInt[AddrWidth:0];

  arb_port_e            prio_q, prio_d;
  logic                 pendValid_q, pendValid_d;
  arb_port_e            pendPort_q, pendPort_d;
  logic                 pendErr_q, pendErr_d;
  logic                 pendRead_q, pendRead_d;
  logic [AddrWidth-1:0] addr_q, addr_d;

  logic                 gntA, gntB, anyGnt;
  logic                 selWe, selSign;
  logic [AddrWidth-1:0] selAddr;
  mem_width_t           selWidth;
  logic [31:0]          selData;
  logic [2:0]           nbytes;
  logic [AddrWidth:0]   lastByte;
  logic                 accessErr;
  logic                 respA, respB;

  // Grant is combinational; nothing is granted while reset is held.
  always_comb begin
    gntA   = !rst_i && a_req_i && (!b_req_i || (prio_q == PORT_A));
    gntB   = !rst_i && b_req_i && !gntA;
    anyGnt = gntA || gntB;

    selWe    = gntB ? b_we_i          : a_we_i;
    selAddr  = gntB ? b_addr_i        : a_addr_i;
    selWidth = gntB ? b_width_i       : a_width_i;
    selSign  = gntB ? b_sign_extend_i : a_sign_extend_i;
    selData  = gntB ? b_data_i        : a_data_i;

    // Last touched byte in AddrWidth+1 bits so a carry past the top is visible.
    nbytes    = width_nbytes(selWidth);
    lastByte  = {1'b0, selAddr} + {{(AddrWidth-2){1'b0}}, nbytes}
              - {{AddrWidth{1'b0}}, 1'b1};
    accessErr = (nbytes == 3'd0) || (lastByte > LastAddr);
  end

  always_comb begin
    mem_addr_o        = anyGnt ? selAddr : addr_q;
    mem_width_o       = selWidth;
    mem_sign_extend_o = selSign;
    mem_data_o        = selData;
    mem_we_o          = anyGnt && selWe && !accessErr;
    a_gnt_o           = gntA;
    b_gnt_o           = gntB;

    respA      = !rst_i && pendValid_q && (pendPort_q == PORT_A);
    respB      = !rst_i && pendValid_q && (pendPort_q == PORT_B);
    a_rvalid_o = respA;
    b_rvalid_o = respB;
    a_err_o    = respA && pendErr_q;
    b_err_o    = respB && pendErr_q;
    a_rdata_o  = (respA && !pendErr_q && pendRead_q) ? mem_data_i : '0;
    b_rdata_o  = (respB && !pendErr_q && pendRead_q) ? mem_data_i : '0;
  end

  always_comb begin
    addr_d      = mem_addr_o;
    pendValid_d = anyGnt;
    pendPort_d  = gntB ? PORT_B : PORT_A;
    pendErr_d   = accessErr;
    pendRead_d  = !selWe;
    prio_d      = prio_q;
    if (a_req_i && b_req_i) begin
      prio_d = (prio_q == PORT_A) ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= PORT_A;
      pendValid_q <= 1'b0;
      pendPort_q  <= PORT_A;
      pendErr_q   <= 1'b0;
      pendRead_q  <= 1'b0;
      addr_q      <= '0;
    end else begin
      prio_q      <= prio_d;
      pendValid_q <= pendValid_d;
      pendPort_q  <= pendPort_d;
      pendErr_q   <= pendErr_d;
      pendRead_q  <= pendRead_d;
      addr_q      <= addr_d;
    end
  end

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a byte-array reference model of the arbiter and memory.
module tb_hippo_mem_arbiter;
  import mem_cfg_pkg::*;

  localparam int Depth = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        aReq, aWe, aSign, bReq, bWe, bSign;
  logic [9:0]  aAddr, bAddr;
  mem_width_t  aWidth, bWidth;
  logic [31:0] aData, bData;
  logic        aGnt, aRvalid, aErr, bGnt, bRvalid, bErr;
  logic [31:0] aRdata, bRdata;
  logic [9:0]  memAddr;
  mem_width_t  memWidth;
  logic        memSign, memWe;
  logic [31:0] memWdata, memRdata;

  always #5 clk = ~clk;

  hippo_mem_arbiter #(.MEMORY_DEPTH_BYTES(Depth)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(aReq), .a_we_i(aWe), .a_addr_i(aAddr), .a_width_i(aWidth),
    .a_sign_extend_i(aSign), .a_data_i(aData), .a_gnt_o(aGnt),
    .a_rvalid_o(aRvalid), .a_err_o(aErr), .a_rdata_o(aRdata),
    .b_req_i(bReq), .b_we_i(bWe), .b_addr_i(bAddr), .b_width_i(bWidth),
    .b_sign_extend_i(bSign), .b_data_i(bData), .b_gnt_o(bGnt),
    .b_rvalid_o(bRvalid), .b_err_o(bErr), .b_rdata_o(bRdata),
    .mem_addr_o(memAddr), .mem_width_o(memWidth), .mem_sign_extend_o(memSign),
    .mem_data_o(memWdata), .mem_we_o(memWe), .mem_data_i(memRdata)
  );

  interleaved_memory #(.MEMORY_DEPTH_BYTES(Depth)) mem (
    .clk_i(clk), .addr_i(memAddr), .width_i(memWidth), .sign_extend_i(memSign),
    .data_i(memWdata), .we_i(memWe), .data_o(memRdata)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  refMem [Depth];
  int          refPrio = 0;
  bit          pendValid = 0;
  int          pendPort = 0;
  bit          pendErr = 0;
  logic [31:0] pendData = 0;
  bit          lastGntA = 0, lastGntB = 0;
  logic [31:0] obsARdata, obsBRdata;
  bit          obsAGnt, obsBGnt, obsARvalid, obsBRvalid, obsAErr, obsMemWe;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int refBytes(mem_width_t w);
    if (w == MEM_BYTE) return 1;
    if (w == MEM_HALFWORD) return 2;
    if (w == MEM_WORD) return 4;
    return 0;
  endfunction

  function automatic bit refErr(logic [9:0] addr, mem_width_t w);
    int nb = refBytes(w);
    return (nb == 0) || (int'(addr) + nb > Depth);
  endfunction

  function automatic logic [31:0] refRead(logic [9:0] addr, mem_width_t w, bit sign);
    int nb = refBytes(w);
    longint v = 0;
    for (int i = 0; i < nb; i++) v += longint'(refMem[(int'(addr) + i) % Depth]) << (8 * i);
    if (sign && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return 32'(v);
  endfunction

  // One clock: predict, check at negedge, advance the model at posedge.
  task automatic runCycle();
    bit expA = 0, expB = 0, sWe, sSign, sErr;
    logic [9:0] sAddr;
    mem_width_t sWidth;
    logic [31:0] sData;
    bit rvA, rvB;
    if (!rst) begin
      if (aReq && bReq) begin
        expA = (refPrio == 0);
        expB = !expA;
      end else begin
        expA = aReq;
        expB = bReq;
      end
    end
    sWe = expB ? bWe : aWe;
    sAddr = expB ? bAddr : aAddr;
    sWidth = expB ? bWidth : aWidth;
    sSign = expB ? bSign : aSign;
    sData = expB ? bData : aData;
    sErr = refErr(sAddr, sWidth);
    rvA = !rst && pendValid && pendPort == 0;
    rvB = !rst && pendValid && pendPort == 1;

    @(negedge clk);
    obsAGnt = aGnt; obsBGnt = bGnt; obsARvalid = aRvalid; obsBRvalid = bRvalid;
    obsAErr = aErr; obsMemWe = memWe; obsARdata = aRdata; obsBRdata = bRdata;
    checkOutput("a_gnt", 32'(aGnt), 32'(expA));
    checkOutput("b_gnt", 32'(bGnt), 32'(expB));
    checkOutput("a_rvalid", 32'(aRvalid), 32'(rvA));
    checkOutput("b_rvalid", 32'(bRvalid), 32'(rvB));
    checkOutput("a_err", 32'(aErr), 32'(rvA && pendErr));
    checkOutput("b_err", 32'(bErr), 32'(rvB && pendErr));
    checkOutput("a_rdata", aRdata, rvA ? pendData : 32'h0);
    checkOutput("b_rdata", bRdata, rvB ? pendData : 32'h0);
    checkOutput("mem_we", 32'(memWe), 32'((expA || expB) && sWe && !sErr));
    if (expA || expB) checkOutput("mem_addr", 32'(memAddr), 32'(sAddr));

    @(posedge clk);
    if (rst) begin
      refPrio = 0;
      pendValid = 0;
    end else begin
      pendValid = expA || expB;
      pendPort = expB ? 1 : 0;
      pendErr = sErr;
      pendData = (!sWe && !sErr) ? refRead(sAddr, sWidth, sSign) : 32'h0;
      if ((expA || expB) && sWe && !sErr)
        for (int i = 0; i < refBytes(sWidth); i++)
          refMem[(int'(sAddr) + i) % Depth] = sData[8*i +: 8];
      if (aReq && bReq) refPrio = 1 - refPrio;
    end
    lastGntA = expA;
    lastGntB = expB;
    #1;
  endtask

  task automatic setA(input bit req, input bit we, input logic [9:0] addr,
                      input mem_width_t w, input bit sign, input logic [31:0] data);
    aReq = req; aWe = we; aAddr = addr; aWidth = w; aSign = sign; aData = data;
  endtask

  task automatic setB(input bit req, input bit we, input logic [9:0] addr,
                      input mem_width_t w, input bit sign, input logic [31:0] data);
    bReq = req; bWe = we; bAddr = addr; bWidth = w; bSign = sign; bData = data;
  endtask

  function automatic mem_width_t randWidth();
    int r = $urandom_range(0, 15);
    if (r < 5) return MEM_BYTE;
    if (r < 10) return MEM_HALFWORD;
    if (r < 15) return MEM_WORD;
    return mem_width_t'(2'd3);
  endfunction

  function automatic logic [9:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 10'($urandom_range(1015, 1023));
    return 10'($urandom_range(0, 1023));
  endfunction

  // Ports hold their request until granted, then may pick a new one.
  task automatic applyStimulus();
    rst = ($urandom_range(0, 63) == 0);
    if (!aReq || lastGntA)
      setA($urandom_range(0, 3) != 0, 1'($urandom), randAddr(), randWidth(),
           1'($urandom), $urandom);
    if (!bReq || lastGntB)
      setB($urandom_range(0, 3) != 0, 1'($urandom), randAddr(), randWidth(),
           1'($urandom), $urandom);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1;
    setA(0, 0, 0, MEM_WORD, 0, 0);
    setB(0, 0, 0, MEM_WORD, 0, 0);
    #1;
    runCycle();
    runCycle();
    rst = 0;

    for (int i = 0; i < Depth / 4; i++) begin
      setA(1, 1, 10'(i * 4), MEM_WORD, 0, $urandom);
      runCycle();
    end

    setA(1, 1, 10'h10, MEM_WORD, 0, 32'hDEADBEEF);
    runCycle();
    setA(1, 0, 10'h10, MEM_WORD, 0, 0);
    runCycle();
    checkOutput("plan_rd_gnt", 32'(obsAGnt), 32'd1);
    setA(0, 0, 10'h10, MEM_WORD, 0, 0);
    runCycle();
    checkOutput("plan_rd_rvalid", 32'(obsARvalid), 32'd1);
    checkOutput("plan_rd_data", obsARdata, 32'hDEADBEEF);
    checkOutput("plan_rd_b_rvalid", 32'(obsBRvalid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      setA(1, 0, 10'(i * 8), MEM_WORD, 0, 0);
      setB(1, 0, 10'(i * 8 + 4), MEM_WORD, 0, 0);
      runCycle();
      checkOutput("alt_a_gnt", 32'(obsAGnt), 32'(i % 2 == 0));
    end

    setA(0, 0, 0, MEM_WORD, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) setA(1, 0, 10'h20, MEM_WORD, 0, 0);
      if (i == 4) setA(0, 0, 10'h20, MEM_WORD, 0, 0);
      setB(1, 0, 10'(i * 4), MEM_WORD, 0, 0);
      runCycle();
      checkOutput("rr_b_gnt", 32'(obsBGnt), 32'(i != 3));
    end

    setB(1, 1, 10'h13, MEM_BYTE, 0, 32'h80);
    runCycle();
    setB(1, 0, 10'h13, MEM_BYTE, 1, 0);
    runCycle();
    setB(1, 0, 10'h13, MEM_BYTE, 0, 0);
    runCycle();
    checkOutput("sext_byte", obsBRdata, 32'hFFFFFF80);
    setB(0, 0, 0, MEM_BYTE, 0, 0);
    runCycle();
    checkOutput("zext_byte", obsBRdata, 32'h00000080);

    setA(1, 1, 10'h3FE, MEM_WORD, 0, 32'h12345678);
    runCycle();
    checkOutput("oob_we", 32'(obsMemWe), 32'd0);
    setA(1, 0, 10'h3FC, MEM_WORD, 0, 0);
    runCycle();
    checkOutput("oob_err", 32'(obsAErr), 32'd1);
    setA(0, 0, 0, MEM_WORD, 0, 0);
    runCycle();
    checkOutput("oob_unchanged", obsARdata, refRead(10'h3FC, MEM_WORD, 0));

    setA(1, 0, 10'h40, MEM_WORD, 0, 0);
    runCycle();
    setA(0, 0, 0, MEM_WORD, 0, 0);
    rst = 1;
    runCycle();
    checkOutput("rst_no_rvalid", 32'(obsARvalid), 32'd0);
    rst = 0;
    runCycle();
    checkOutput("post_rst_no_rvalid", 32'(obsARvalid), 32'd0);
    setA(1, 0, 10'h44, MEM_WORD, 0, 0);
    setB(1, 0, 10'h48, MEM_WORD, 0, 0);
    runCycle();
    checkOutput("post_rst_prio_a", 32'(obsAGnt), 32'd1);

    setA(0, 0, 0, MEM_WORD, 0, 0);
    setB(0, 0, 0, MEM_WORD, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
